// File: rtl/timer_arbiter_4ch.sv
`default_nettype none
// ============================================================================
//  Module   : timer_arbiter_4ch
//  Purpose  : Round-robin scheduler sharing one WIDTH-bit interval counter
//             among four requesters, with rco terminal flag and done pulses.
//  Revision : 1.0  initial release
// ============================================================================
module timer_arbiter_4ch #(
   parameter int WIDTH = 10
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [3:0]         req_i,
   input  logic [4*WIDTH-1:0] len_i,
   output logic [3:0]         gnt_o,
   output logic               busy_o,
   output logic [WIDTH-1:0]   count_o,
   output logic               rco_o,
   output logic [3:0]         done_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q;
   logic [1:0]         ptr_q;     // last granted channel; also the active job's owner
   logic [WIDTH-1:0]   term_q;    // count value of the final RUN cycle
   logic [3:0]         gnt_q;
   logic               busy_q;
   logic [WIDTH-1:0]   count_q;
   logic [3:0]         done_q;

   logic               win_valid;
   logic [1:0]         win_idx;
   logic [WIDTH-1:0]   win_len;
   logic               terminal;

   // Round-robin search starting just after the last granted channel
   always_comb begin
      win_valid = 1'b0;
      win_idx   = ptr_q;
      for (int k = 1; k <= 4; k++) begin
         logic [1:0] cand;
         cand = ptr_q + 2'(k);
         if (!win_valid && req_i[cand]) begin
            win_valid = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Length of the prospective winner; only sampled on the grant edge
   assign win_len  = len_i[win_idx*WIDTH +: WIDTH];

   assign terminal = (state_q == S_RUN) && (count_q == term_q);

   // Scheduler FSM with registered grant, counter and completion outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         ptr_q   <= 2'd3;
         term_q  <= '0;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
         count_q <= '0;
         done_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= '0;
               if (win_valid) begin
                  state_q <= S_RUN;
                  ptr_q   <= win_idx;
                  gnt_q   <= 4'b0001 << win_idx;
                  busy_q  <= 1'b1;
                  count_q <= '0;
                  // len 0 wraps to all-ones, giving the full 2^WIDTH interval
                  term_q  <= win_len - WIDTH'(1);
               end
            end
            S_RUN: begin
               // Completion has priority over a simultaneous request drop
               if (terminal) begin
                  state_q <= S_DONE;
                  done_q  <= gnt_q;
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
                  count_q <= '0;
               end else if (!req_i[ptr_q]) begin
                  state_q <= S_IDLE;
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
                  count_q <= '0;
               end else begin
                  count_q <= count_q + WIDTH'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= '0;
            end
            default: begin
               state_q <= S_IDLE;
               gnt_q   <= '0;
               busy_q  <= 1'b0;
               count_q <= '0;
               done_q  <= '0;
            end
         endcase
      end
   end

   assign gnt_o   = gnt_q;
   assign busy_o  = busy_q;
   assign count_o = count_q;
   assign done_o  = done_q;
   assign rco_o   = terminal;

endmodule
`default_nettype wire

// File: tb/tb_timer_arbiter_4ch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_arbiter_4ch
//  Purpose  : Self-checking bench for timer_arbiter_4ch (vector table plus
//             hand-written multi-cycle sequences).
//  Revision : 1.0  initial release
// ============================================================================
module tb_timer_arbiter_4ch;

   localparam int WIDTH = 10;

   logic               clk;
   logic               rst_n;
   logic [3:0]         req;
   logic [4*WIDTH-1:0] len;
   logic [3:0]         gnt;
   logic               busy;
   logic [WIDTH-1:0]   count;
   logic               rco;
   logic [3:0]         done;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string              name;
      logic               rst_n;
      logic [3:0]         req;
      logic [4*WIDTH-1:0] len;
      logic [3:0]         gnt;
      logic               busy;
      int                 count;
      logic               rco;
      logic [3:0]         done;
   } vec_t;

   vec_t tbl[$];

   timer_arbiter_4ch #(.WIDTH(WIDTH)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .req_i   (req),
      .len_i   (len),
      .gnt_o   (gnt),
      .busy_o  (busy),
      .count_o (count),
      .rco_o   (rco),
      .done_o  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4*WIDTH-1:0] pack_len(input int l0, input int l1,
                                                   input int l2, input int l3);
      return {WIDTH'(l3), WIDTH'(l2), WIDTH'(l1), WIDTH'(l0)};
   endfunction

   function automatic void add(input string nm, input logic r, input logic [3:0] q,
                               input logic [4*WIDTH-1:0] l, input logic [3:0] g,
                               input logic b, input int c, input logic ro,
                               input logic [3:0] d);
      vec_t v;
      v.name = nm; v.rst_n = r; v.req = q; v.len = l;
      v.gnt = g; v.busy = b; v.count = c; v.rco = ro; v.done = d;
      tbl.push_back(v);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [3:0] g, input logic b,
                      input int c, input logic ro, input logic [3:0] d);
      checks++;
      if (gnt !== g || busy !== b || count !== WIDTH'(c) || rco !== ro || done !== d) begin
         errors++;
         $display("FAIL %s: got gnt=%b busy=%b count=%0d rco=%b done=%b, want gnt=%b busy=%b count=%0d rco=%b done=%b",
                  nm, gnt, busy, count, rco, done, g, b, c, ro, done === d ? done : d);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 4'b0000;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [4*WIDTH-1:0] l5, l2, l1;
      logic [3:0]         oh;
      bit                 run_ok;
      int                 rco_hits;

      rst_n = 1'b0;
      req   = 4'b0000;
      len   = '0;

      // ---- Section A: reset, single channel-0 job of length 5 -----------
      l5 = pack_len(5, 2, 2, 2);
      add("reset",     1'b0, 4'b0001, l5, 4'b0000, 1'b0, 0, 1'b0, 4'b0000);
      add("a_grant",   1'b1, 4'b0001, l5, 4'b0001, 1'b1, 0, 1'b0, 4'b0000);
      for (int i = 1; i <= 4; i++)
         add($sformatf("a_count%0d", i), 1'b1, 4'b0001, l5, 4'b0001, 1'b1, i, (i == 4), 4'b0000);
      add("a_done",    1'b1, 4'b0001, l5, 4'b0000, 1'b0, 0, 1'b0, 4'b0001);
      add("a_idle",    1'b1, 4'b0001, l5, 4'b0000, 1'b0, 0, 1'b0, 4'b0000);
      add("a_regrant", 1'b1, 4'b0001, l5, 4'b0001, 1'b1, 0, 1'b0, 4'b0000);
      add("a_abort",   1'b1, 4'b0000, l5, 4'b0000, 1'b0, 0, 1'b0, 4'b0000);
      add("a_nodone",  1'b1, 4'b0000, l5, 4'b0000, 1'b0, 0, 1'b0, 4'b0000);

      // ---- Section B: round-robin over all four, length 2 each ----------
      l2 = pack_len(2, 2, 2, 2);
      add("b_reset",   1'b0, 4'b1111, l2, 4'b0000, 1'b0, 0, 1'b0, 4'b0000);
      for (int k = 0; k < 5; k++) begin
         oh = 4'b0001 << (k % 4);
         add($sformatf("b_grant%0d", k), 1'b1, 4'b1111, l2, oh,      1'b1, 0, 1'b0, 4'b0000);
         add($sformatf("b_rco%0d", k),   1'b1, 4'b1111, l2, oh,      1'b1, 1, 1'b1, 4'b0000);
         add($sformatf("b_done%0d", k),  1'b1, 4'b1111, l2, 4'b0000, 1'b0, 0, 1'b0, oh);
         add($sformatf("b_idle%0d", k),  1'b1, 4'b1111, l2, 4'b0000, 1'b0, 0, 1'b0, 4'b0000);
      end

      // ---- Section C: minimum length on channel 1 ------------------------
      l1 = pack_len(2, 1, 2, 2);
      add("c_reset",   1'b0, 4'b0010, l1, 4'b0000, 1'b0, 0, 1'b0, 4'b0000);
      add("c_grant",   1'b1, 4'b0010, l1, 4'b0010, 1'b1, 0, 1'b1, 4'b0000);
      add("c_done",    1'b1, 4'b0010, l1, 4'b0000, 1'b0, 0, 1'b0, 4'b0010);
      add("c_idle",    1'b1, 4'b0010, l1, 4'b0000, 1'b0, 0, 1'b0, 4'b0000);

      #2;
      chk("initial_reset", 4'b0000, 1'b0, 0, 1'b0, 4'b0000);

      foreach (tbl[i]) begin
         rst_n = tbl[i].rst_n;
         req   = tbl[i].req;
         len   = tbl[i].len;
         step();
         chk(tbl[i].name, tbl[i].gnt, tbl[i].busy, tbl[i].count, tbl[i].rco, tbl[i].done);
      end

      // ---- Maximum length: len1=0 means 1024 RUN cycles ------------------
      len = pack_len(2, 0, 2, 2);
      step();
      run_ok   = 1'b1;
      rco_hits = 0;
      for (int i = 0; i < 1024; i++) begin
         if (gnt !== 4'b0010 || busy !== 1'b1 || count !== WIDTH'(i) ||
             rco !== (i == 1023) || done !== 4'b0000)
            run_ok = 1'b0;
         if (rco === 1'b1) rco_hits++;
         if (i < 1023) step();
      end
      checks++;
      if (!run_ok || count !== WIDTH'(1023)) begin
         errors++;
         $display("FAIL max_len_run: got final count=%0d per-cycle ok=%0d, want count=1023 ok=1", count, run_ok);
      end
      checks++;
      if (rco_hits != 1) begin
         errors++;
         $display("FAIL max_len_rco: got %0d rco cycles, want 1", rco_hits);
      end
      step();
      chk("max_len_done", 4'b0000, 1'b0, 0, 1'b0, 4'b0010);

      // ---- Abort, then request drop coinciding with rco ------------------
      do_reset();
      req = 4'b0100;
      len = pack_len(2, 2, 10, 2);
      step();
      chk("abort_grant", 4'b0100, 1'b1, 0, 1'b0, 4'b0000);
      step(); step(); step();
      chk("abort_count3", 4'b0100, 1'b1, 3, 1'b0, 4'b0000);
      req = 4'b0000;
      step();
      chk("abort_gnt", 4'b0000, 1'b0, 0, 1'b0, 4'b0000);
      step();
      chk("abort_nodone", 4'b0000, 1'b0, 0, 1'b0, 4'b0000);
      req = 4'b0100;
      step();
      chk("simul_grant", 4'b0100, 1'b1, 0, 1'b0, 4'b0000);
      for (int i = 0; i < 9; i++) step();
      chk("simul_rco", 4'b0100, 1'b1, 9, 1'b1, 4'b0000);
      req = 4'b0000;
      step();
      chk("simul_done", 4'b0000, 1'b0, 0, 1'b0, 4'b0100);

      // ---- Asynchronous reset mid-job on channel 3 -----------------------
      do_reset();
      req = 4'b1000;
      len = pack_len(4, 2, 2, 10);
      step();
      chk("ch3_grant", 4'b1000, 1'b1, 0, 1'b0, 4'b0000);
      for (int i = 0; i < 6; i++) step();
      chk("ch3_count6", 4'b1000, 1'b1, 6, 1'b0, 4'b0000);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", 4'b0000, 1'b0, 0, 1'b0, 4'b0000);
      req = 4'b1001;
      #1 rst_n = 1'b1;
      step();
      chk("post_reset_ch0", 4'b0001, 1'b1, 0, 1'b0, 4'b0000);

      // ---- Length changes after grant are ignored ------------------------
      len = pack_len(9, 2, 2, 10);
      step();
      chk("len_stable_c1", 4'b0001, 1'b1, 1, 1'b0, 4'b0000);
      step(); step();
      chk("len_stable_rco", 4'b0001, 1'b1, 3, 1'b1, 4'b0000);
      step();
      chk("len_stable_done", 4'b0000, 1'b0, 0, 1'b0, 4'b0001);
      step();
      step();
      chk("rr_next_ch3", 4'b1000, 1'b1, 0, 1'b0, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
